// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-side types: word, RAM handshake state, arbiter FSM state
// and the latched request payload used by mem_arbiter.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DGRANT = 3'd1,
    IGRANT = 3'd2,
    TURN   = 3'd3,
    ERR    = 3'd4
  } arb_state_t;

  // Request captured at grant time and replayed onto the RAM port.
  typedef struct packed {
    word_t addr;
    word_t store;
    logic  wr;
  } arb_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of request-side (fetch/data) and RAM-side signals around mem_arbiter.
//   slave  : arbiter view (takes requests + RAM status, drives hits + RAM port)
//   master : environment view (drives requests + RAM status, observes the rest)
interface mem_arbiter_if;
  import cpu_types_pkg::*;

  logic      iREN;
  word_t     iaddr;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      ihit;
  word_t     iload;
  logic      dhit;
  word_t     dload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  logic      memerr;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, memerr
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, memerr
  );

endinterface

// File: rtl/mem_arbiter_access_watchdog.sv
// Cycle counter for a granted RAM access; flags when the access has waited
// TIMEOUT cycles.
//   clk, rst  : clock, synchronous active-high reset
//   clr       : restart the count (held while no access is granted)
//   en        : count this cycle
//   timeout_c : combinational, high in the TIMEOUT-th counted cycle
module access_watchdog #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout_c
);

  logic [CNT_W-1:0] cnt;

  // First granted cycle sees cnt==0, so cnt==TIMEOUT-1 marks the TIMEOUT-th.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign timeout_c = en && (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data reads/writes take priority over instruction
// fetch; each access completes with a one-cycle ihit/dhit when the RAM reports
// ACCESS, followed by one turnaround cycle. A watchdog and RAM ERROR status
// push the block into an absorbing error state with a sticky memerr flag.
//   CLK, Rst : clock, synchronous active-high reset
//   bus      : request side (iREN/iaddr, dREN/dWEN/daddr/dstore, hits/loads)
//              and RAM side (ramREN/ramWEN/ramaddr/ramstore, ramload/ramstate)
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic          CLK,
  input  logic          Rst,
  mem_arbiter_if.slave  bus
);

  arb_state_t state, next_state;
  arb_req_t   req_q, req_d;
  logic       memerr_q;
  logic       in_grant;
  logic       timeout_c;
  logic       d_req;

  logic  ihit, dhit, ram_ren, ram_wen;
  word_t iload, dload, ram_addr, ram_store;

  assign in_grant = (state == DGRANT) || (state == IGRANT);

  access_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_watchdog (
    .clk       (CLK),
    .rst       (Rst),
    .clr       (!in_grant),
    .en        (in_grant),
    .timeout_c (timeout_c)
  );

  // State, latched request and sticky error flag.
  always_ff @(posedge CLK) begin
    if (Rst) begin
      state    <= IDLE;
      req_q    <= '0;
      memerr_q <= 1'b0;
    end else begin
      state <= next_state;
      req_q <= req_d;
      if (next_state == ERR) begin
        memerr_q <= 1'b1;
      end
    end
  end

  // Next state, RAM port drive and completion pulses.
  always_comb begin
    next_state = state;
    req_d      = req_q;
    ihit       = 1'b0;
    iload      = '0;
    dhit       = 1'b0;
    dload      = '0;
    ram_ren    = 1'b0;
    ram_wen    = 1'b0;
    ram_addr   = '0;
    ram_store  = '0;
    d_req      = bus.dREN | bus.dWEN;

    case (state)
      IDLE: begin
        if (d_req) begin
          next_state = DGRANT;
          req_d      = '{addr: bus.daddr, store: bus.dstore, wr: bus.dWEN};
        end else if (bus.iREN) begin
          next_state = IGRANT;
          req_d      = '{addr: bus.iaddr, store: '0, wr: 1'b0};
        end
      end

      DGRANT: begin
        // Enables follow the live request so a dropped request stops at once.
        if (d_req) begin
          ram_addr  = req_q.addr;
          ram_wen   = req_q.wr;
          ram_ren   = !req_q.wr;
          ram_store = req_q.wr ? req_q.store : '0;
        end
        if (bus.ramstate == ERROR) begin
          next_state = ERR;
        end else if (!d_req) begin
          next_state = IDLE;
        end else if (bus.ramstate == ACCESS) begin
          dhit       = 1'b1;
          dload      = bus.ramload;
          next_state = TURN;
        end else if (timeout_c) begin
          next_state = ERR;
        end
      end

      IGRANT: begin
        if (bus.iREN) begin
          ram_addr = req_q.addr;
          ram_ren  = 1'b1;
        end
        if (bus.ramstate == ERROR) begin
          next_state = ERR;
        end else if (!bus.iREN) begin
          next_state = IDLE;
        end else if (bus.ramstate == ACCESS) begin
          ihit       = 1'b1;
          iload      = bus.ramload;
          next_state = TURN;
        end else if (timeout_c) begin
          next_state = ERR;
        end
      end

      TURN:    next_state = IDLE;
      ERR:     next_state = ERR;
      default: next_state = IDLE;
    endcase

    // Nothing leaves the block while reset is asserted.
    if (Rst) begin
      next_state = IDLE;
      ihit       = 1'b0;
      iload      = '0;
      dhit       = 1'b0;
      dload      = '0;
      ram_ren    = 1'b0;
      ram_wen    = 1'b0;
      ram_addr   = '0;
      ram_store  = '0;
    end
  end

  assign bus.ihit     = ihit;
  assign bus.iload    = iload;
  assign bus.dhit     = dhit;
  assign bus.dload    = dload;
  assign bus.ramREN   = ram_ren;
  assign bus.ramWEN   = ram_wen;
  assign bus.ramaddr  = ram_addr;
  assign bus.ramstore = ram_store;
  assign bus.memerr   = memerr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic CLK;
  logic Rst;
  int   errors;
  int   checks;

  mem_arbiter_if bus();

  mem_arbiter #(.TIMEOUT(64), .CNT_W(7)) dut (
    .CLK (CLK),
    .Rst (Rst),
    .bus (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Inputs change 2 time units after the rising edge; checks happen 1 unit later.
  task automatic next_cycle();
    @(posedge CLK);
    #2;
  endtask

  task automatic idle_inputs();
    bus.iREN     = 1'b0;
    bus.iaddr    = '0;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.ramload  = '0;
    bus.ramstate = FREE;
  endtask

  task automatic test_reset();
    idle_inputs();
    Rst = 1'b1;
    next_cycle();
    bus.iREN     = 1'b1;
    bus.dREN     = 1'b1;
    bus.ramstate = ACCESS;
    #1;
    checks++;
    if (bus.ramREN !== 1'b0 || bus.dhit !== 1'b0 || bus.ihit !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: ramREN=%b dhit=%b ihit=%b required 0 0 0", bus.ramREN, bus.dhit, bus.ihit);
    end
    idle_inputs();
    next_cycle();
    Rst = 1'b0;
    #1;
    checks++;
    if (dut.state !== IDLE || bus.memerr !== 1'b0 || bus.ramaddr !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: state=%0d memerr=%b ramaddr=%h required 0 0 0", dut.state, bus.memerr, bus.ramaddr);
    end
  endtask

  task automatic test_ifetch();
    int ren_cycles;
    ren_cycles = 0;
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h40;
    bus.ramstate = BUSY;
    #1;
    checks++;
    if (bus.ramREN !== 1'b0) begin
      errors++;
      $display("FAIL ifetch_idle_ren: ramREN=%b required 0", bus.ramREN);
    end
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      if (c == 2) begin
        bus.ramstate = ACCESS;
        bus.ramload  = 32'h8C220004;
      end
      #1;
      if (bus.ramREN === 1'b1 && bus.ramaddr === 32'h40) ren_cycles++;
      checks++;
      if (bus.ihit !== (c == 2)) begin
        errors++;
        $display("FAIL ifetch_ihit_c%0d: ihit=%b required %b", c, bus.ihit, (c == 2));
      end
    end
    checks++;
    if (bus.iload !== 32'h8C220004) begin
      errors++;
      $display("FAIL ifetch_iload: iload=%h required 8c220004", bus.iload);
    end
    checks++;
    if (ren_cycles != 3) begin
      errors++;
      $display("FAIL ifetch_ren_cycles: got %0d required 3", ren_cycles);
    end
    next_cycle();
    bus.iREN     = 1'b0;
    bus.ramstate = FREE;
    bus.ramload  = '0;
    #1;
    checks++;
    if (dut.state !== TURN || bus.ihit !== 1'b0 || bus.ramREN !== 1'b0) begin
      errors++;
      $display("FAIL ifetch_turn: state=%0d ihit=%b ramREN=%b required 3 0 0", dut.state, bus.ihit, bus.ramREN);
    end
    next_cycle();
  endtask

  task automatic test_priority();
    bus.iREN   = 1'b1;
    bus.iaddr  = 32'h80;
    bus.dWEN   = 1'b1;
    bus.daddr  = 32'h100;
    bus.dstore = 32'hDEADBEEF;
    next_cycle();
    bus.ramstate = ACCESS;
    #1;
    checks++;
    if (dut.state !== DGRANT || bus.ramWEN !== 1'b1 || bus.ramREN !== 1'b0) begin
      errors++;
      $display("FAIL prio_dgrant: state=%0d ramWEN=%b ramREN=%b required 1 1 0", dut.state, bus.ramWEN, bus.ramREN);
    end
    checks++;
    if (bus.ramaddr !== 32'h100 || bus.ramstore !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL prio_write_bus: ramaddr=%h ramstore=%h required 00000100 deadbeef", bus.ramaddr, bus.ramstore);
    end
    checks++;
    if (bus.dhit !== 1'b1 || bus.ihit !== 1'b0) begin
      errors++;
      $display("FAIL prio_dhit: dhit=%b ihit=%b required 1 0", bus.dhit, bus.ihit);
    end
    next_cycle();
    bus.dWEN     = 1'b0;
    bus.ramstate = FREE;
    #1;
    checks++;
    if (bus.ramWEN !== 1'b0 || bus.dhit !== 1'b0) begin
      errors++;
      $display("FAIL prio_turn: ramWEN=%b dhit=%b required 0 0", bus.ramWEN, bus.dhit);
    end
    next_cycle();
    next_cycle();
    bus.ramstate = ACCESS;
    bus.ramload  = 32'h12345678;
    #1;
    checks++;
    if (dut.state !== IGRANT || bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h80) begin
      errors++;
      $display("FAIL prio_fetch_grant: state=%0d ramREN=%b ramaddr=%h required 2 1 00000080", dut.state, bus.ramREN, bus.ramaddr);
    end
    checks++;
    if (bus.ihit !== 1'b1 || bus.iload !== 32'h12345678) begin
      errors++;
      $display("FAIL prio_ihit: ihit=%b iload=%h required 1 12345678", bus.ihit, bus.iload);
    end
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_back_to_back();
    int reads;
    int hits;
    int turn_reads;
    reads = 0;
    hits = 0;
    turn_reads = 0;
    bus.dREN     = 1'b1;
    bus.daddr    = 32'h200;
    bus.ramstate = ACCESS;
    bus.ramload  = 32'hA5A5A5A5;
    for (int c = 0; c < 6; c++) begin
      if (c == 5) bus.dREN = 1'b0;
      #1;
      if (bus.ramREN === 1'b1) reads++;
      if (bus.dhit === 1'b1) hits++;
      if (dut.state == TURN && bus.ramREN === 1'b1) turn_reads++;
      next_cycle();
    end
    checks++;
    if (reads != 2) begin
      errors++;
      $display("FAIL b2b_reads: got %0d required 2", reads);
    end
    checks++;
    if (hits != 2) begin
      errors++;
      $display("FAIL b2b_dhits: got %0d required 2", hits);
    end
    checks++;
    if (turn_reads != 0) begin
      errors++;
      $display("FAIL b2b_turn_read: got %0d required 0", turn_reads);
    end
    idle_inputs();
    #1;
    checks++;
    if (dut.state !== IDLE) begin
      errors++;
      $display("FAIL b2b_end_idle: state=%0d required 0", dut.state);
    end
  endtask

  task automatic test_abort();
    bus.iREN     = 1'b1;
    bus.iaddr    = 32'h44;
    bus.ramstate = BUSY;
    next_cycle();
    #1;
    checks++;
    if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h44) begin
      errors++;
      $display("FAIL abort_grant: ramREN=%b ramaddr=%h required 1 00000044", bus.ramREN, bus.ramaddr);
    end
    next_cycle();
    bus.iREN = 1'b0;
    #1;
    checks++;
    if (bus.ramREN !== 1'b0 || bus.ihit !== 1'b0) begin
      errors++;
      $display("FAIL abort_drop: ramREN=%b ihit=%b required 0 0", bus.ramREN, bus.ihit);
    end
    next_cycle();
    bus.ramstate = ACCESS;
    bus.ramload  = 32'hFFFF0000;
    #1;
    checks++;
    if (dut.state !== IDLE || bus.ihit !== 1'b0 || bus.dhit !== 1'b0 || bus.iload !== 32'h0) begin
      errors++;
      $display("FAIL abort_idle: state=%0d ihit=%b dhit=%b iload=%h required 0 0 0 0", dut.state, bus.ihit, bus.dhit, bus.iload);
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_timeout();
    bus.dREN     = 1'b1;
    bus.daddr    = 32'h300;
    bus.ramstate = BUSY;
    // 64 cycles waiting in DGRANT; the error state is entered after the 64th.
    for (int c = 1; c <= 64; c++) begin
      next_cycle();
      #1;
      if (c == 1 || c == 64) begin
        checks++;
        if (dut.state !== DGRANT || bus.memerr !== 1'b0) begin
          errors++;
          $display("FAIL timeout_wait_c%0d: state=%0d memerr=%b required 1 0", c, dut.state, bus.memerr);
        end
      end
    end
    next_cycle();
    #1;
    checks++;
    if (dut.state !== ERR || bus.memerr !== 1'b1) begin
      errors++;
      $display("FAIL timeout_err: state=%0d memerr=%b required 4 1", dut.state, bus.memerr);
    end
    bus.ramstate = ACCESS;
    bus.iREN     = 1'b1;
    begin
      int hits;
      hits = 0;
      for (int c = 0; c < 5; c++) begin
        next_cycle();
        #1;
        if (bus.dhit === 1'b1 || bus.ihit === 1'b1 || bus.ramREN === 1'b1) hits++;
      end
      checks++;
      if (hits != 0 || bus.memerr !== 1'b1) begin
        errors++;
        $display("FAIL timeout_sticky: activity=%0d memerr=%b required 0 1", hits, bus.memerr);
      end
    end
    idle_inputs();
    Rst = 1'b1;
    next_cycle();
    Rst = 1'b0;
    #1;
    checks++;
    if (dut.state !== IDLE || bus.memerr !== 1'b0) begin
      errors++;
      $display("FAIL timeout_reset: state=%0d memerr=%b required 0 0", dut.state, bus.memerr);
    end
  endtask

  task automatic test_ram_error();
    bus.dWEN   = 1'b1;
    bus.daddr  = 32'h500;
    bus.dstore = 32'h55;
    next_cycle();
    bus.ramstate = ERROR;
    #1;
    checks++;
    if (bus.dhit !== 1'b0 || bus.memerr !== 1'b0 || bus.ramWEN !== 1'b1) begin
      errors++;
      $display("FAIL ramerr_grant: dhit=%b memerr=%b ramWEN=%b required 0 0 1", bus.dhit, bus.memerr, bus.ramWEN);
    end
    next_cycle();
    bus.ramstate = ACCESS;
    #1;
    checks++;
    if (bus.memerr !== 1'b1 || bus.dhit !== 1'b0 || bus.ramWEN !== 1'b0) begin
      errors++;
      $display("FAIL ramerr_after: memerr=%b dhit=%b ramWEN=%b required 1 0 0", bus.memerr, bus.dhit, bus.ramWEN);
    end
    idle_inputs();
    Rst = 1'b1;
    next_cycle();
    Rst = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    bus.iREN     = 1'b1;
    bus.iaddr    = 32'h60;
    bus.ramstate = BUSY;
    next_cycle();
    Rst          = 1'b1;
    bus.ramstate = ACCESS;
    #1;
    checks++;
    if (bus.ihit !== 1'b0 || bus.ramREN !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_during: ihit=%b ramREN=%b required 0 0", bus.ihit, bus.ramREN);
    end
    next_cycle();
    Rst      = 1'b0;
    bus.iREN = 1'b0;
    #1;
    checks++;
    if (dut.state !== IDLE || bus.ramREN !== 1'b0 || bus.ihit !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_after: state=%0d ramREN=%b ihit=%b required 0 0 0", dut.state, bus.ramREN, bus.ihit);
    end
    idle_inputs();
    next_cycle();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    Rst = 1'b1;
    idle_inputs();
    test_reset();
    test_ifetch();
    test_priority();
    test_back_to_back();
    test_abort();
    test_timeout();
    test_ram_error();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of the request unit and instruction fetch, and upstream of the single-port RAM.
- Arbitrates instruction reads (iREN) and data reads/writes (dREN/dWEN) onto one RAM port.
- Waits on RAM ramstate and returns single-cycle ihit/dhit with load data.
- Data access has priority over fetch. Includes a watchdog timeout and a sticky error flag.

Parameters:
TIMEOUT, 64, max cycles a granted access may wait for ramstate==ACCESS before the block declares an error
CNT_W, 7, watchdog counter width; must satisfy 2**CNT_W > TIMEOUT

Ports:
CLK  in  1  system clock, rising edge
Rst  in  1  synchronous active-high reset
iREN  in  1  instruction read request
iaddr  in  32  instruction address (word_t)
dREN  in  1  data read request
dWEN  in  1  data write request
daddr  in  32  data address
dstore  in  32  data write value
ihit  out  1  instruction access complete, one-cycle pulse
iload  out  32  fetched instruction, valid with ihit
dhit  out  1  data access complete, one-cycle pulse
dload  out  32  read data, valid with dhit
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  32  RAM address
ramstore  out  32  RAM write data
ramload  in  32  RAM read data
ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR
memerr  out  1  sticky error flag

Behaviour:
- Clock and reset: one clock, CLK; reset Rst is synchronous and active-high. All state updates on the CLK rising edge.
- Reset values: state=IDLE, watchdog=0, memerr=0, latched addr/store=0. All outputs 0 during and after reset until a grant.
- FSM states: IDLE, DGRANT, IGRANT, TURN, ERR.
- IDLE:
  - dREN|dWEN goes to DGRANT and latches daddr, dstore, and the write flag (=dWEN).
  - Otherwise iREN goes to IGRANT and latches iaddr.
  - Otherwise stays in IDLE.
  - Data always beats instruction when both are requested in the same cycle.
- dREN and dWEN both high: treated as a write.
- DGRANT drives: ramaddr=latched daddr; ramWEN=write flag; ramREN=!write flag; ramstore=latched dstore (write only, else 0).
- IGRANT drives: ramREN=1, ramaddr=latched iaddr, ramWEN=0.
- IDLE, TURN and ERR drive all ram* outputs to 0.
- Completion:
  - In DGRANT/IGRANT with ramstate==ACCESS, dhit/ihit asserts combinationally in that same cycle.
  - dload/iload=ramload in that cycle, else 0.
  - Next state is TURN.
- TURN: exactly one cycle, then IDLE. This turnaround lets the requester drop its request after the hit, so no duplicate access is issued. Latency from request to hit is at least 2 cycles.
- Abort: if the granted request deasserts before ACCESS (e.g. halt), go to IDLE next cycle with no hit; enables drop that cycle.
- Watchdog:
  - Counts cycles in DGRANT/IGRANT; clears on leaving.
  - If ramstate==ERROR, or the count reaches TIMEOUT without ACCESS, go to ERR and set memerr=1.
- ERR: absorbing state; no hits ever; memerr held at 1. Only Rst exits ERR.
- Reset mid-access: next cycle all enables are 0 and state=IDLE; no hit is produced for the aborted access.
- ACCESS arriving in IDLE/TURN is ignored.

Decomposition:
- Shared package cpu_types_pkg supplies word_t and ramstate_t (FREE/BUSY/ACCESS/ERROR).
- Add arb_state_t (IDLE/DGRANT/IGRANT/TURN/ERR) to that package for bench visibility.
- One sub-module, access_watchdog: counter with clear/enable and a timeout output, parameterised by TIMEOUT and CNT_W.

Test Plan:
- iREN=1, iaddr=0x40; ramstate BUSY 2 cycles then ACCESS with ramload=0x8C220004 -> ramREN=1 and ramaddr=0x40 for 3 cycles; ihit pulses once with iload=0x8C220004; TURN follows.
- iREN=1 and dWEN=1 together, daddr=0x100, dstore=0xDEADBEEF -> write granted first (ramWEN=1, ramstore=0xDEADBEEF); dhit on ACCESS; after TURN, fetch granted; ihit follows.
- dREN=1 held across a TURN cycle -> exactly two RAM reads issued, never a read in TURN; count dhit pulses matches grants.
- IGRANT, then iREN dropped while ramstate=BUSY -> IDLE next cycle; ramREN=0; no ihit.
- ramstate held BUSY for TIMEOUT=64 cycles -> memerr=1 on cycle 64 and stays 1; new requests get no hits; Rst=1 for one cycle clears memerr and returns state to IDLE.
- ramstate=ERROR during DGRANT -> memerr=1 next cycle, dhit never asserts.
